// File: rtl/param_seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: fill modes, direction and FSM states.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_EDGE = 2'b01,
        MODE_FILL = 2'b10,
        MODE_ROT  = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/param_seq_shifter_if.sv
// Request/result bundle of the sequential shifter; master is the requester, slave the shifter.
interface param_seq_shifter_if #(
    parameter int WIDTH = 8
) ();
    import shifter_pkg::*;

    localparam int AW = $clog2(WIDTH);

    // Both ports move data only on an edge where valid && ready; valid never waits for ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amt_in;
    logic             dir_in;
    logic [1:0]       mode_in;
    logic             fill_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             busy;
    state_e           state;

    modport master (
        output in_valid, data_in, amt_in, dir_in, mode_in, fill_in, out_ready,
        input  in_ready, out_valid, data_out, carry_out, busy, state
    );

    modport slave (
        input  in_valid, data_in, amt_in, dir_in, mode_in, fill_in, out_ready,
        output in_ready, out_valid, data_out, carry_out, busy, state
    );

endinterface

// File: rtl/param_seq_shifter_step.sv
// Combinational shifter moving a word by 0..STEP positions, built as a chain of
// single-bit steps so a wide step is exactly equivalent to repeated narrow ones.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int SW    = 1
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [SW-1:0]    s_i,
    input  logic             dir_i,
    input  mode_e            mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] word_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] w;
    logic             c;
    logic             fb;

    always_comb begin
        w  = word_i;
        c  = 1'b0;
        fb = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(s_i)) begin
                if (dir_i == DIR_LEFT) begin
                    c = w[WIDTH-1];
                    case (mode_i)
                        MODE_ZERO: fb = 1'b0;
                        MODE_EDGE: fb = w[0];
                        MODE_FILL: fb = fill_i;
                        default:   fb = w[WIDTH-1];
                    endcase
                    w = {w[WIDTH-2:0], fb};
                end else begin
                    c = w[0];
                    case (mode_i)
                        MODE_ZERO: fb = 1'b0;
                        MODE_EDGE: fb = w[WIDTH-1];
                        MODE_FILL: fb = fill_i;
                        default:   fb = w[0];
                    endcase
                    w = {fb, w[WIDTH-1:1]};
                end
            end
        end
        word_o  = w;
        carry_o = c;
    end

endmodule

// File: rtl/param_seq_shifter.sv
// Multi-cycle shifter: accepts a request, shifts up to STEP positions per clock,
// then holds the result and last exiting bit until the consumer takes it.
module param_seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    param_seq_shifter_if.slave bus
);

    localparam int AW = $clog2(WIDTH);
    localparam int SW = $clog2(STEP + 1);

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic             carry_q;
    logic [AW-1:0]    rem_q;
    logic             dir_q;
    mode_e            mode_q;
    logic             fill_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [SW-1:0]    s_d;
    logic [WIDTH-1:0] word_d;
    logic             carry_d;
    logic [AW-1:0]    rem_d;

    always_comb begin
        if (32'(rem_q) > STEP) s_d = SW'(STEP);
        else                   s_d = SW'(rem_q);
        rem_d = rem_q - AW'(s_d);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .word_i  (word_q),
        .s_i     (s_d),
        .dir_i   (dir_q),
        .mode_i  (mode_q),
        .fill_i  (fill_q),
        .word_o  (word_d),
        .carry_o (carry_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            carry_q     <= 1'b0;
            rem_q       <= '0;
            dir_q       <= DIR_RIGHT;
            mode_q      <= MODE_ZERO;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        word_q     <= bus.data_in;
                        dir_q      <= bus.dir_in;
                        mode_q     <= mode_e'(bus.mode_in);
                        fill_q     <= bus.fill_in;
                        carry_q    <= 1'b0;
                        rem_q      <= bus.amt_in;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.amt_in == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    word_q  <= word_d;
                    carry_q <= carry_d;
                    rem_q   <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready comes back one cycle after the result handshake.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = word_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_param_seq_shifter.sv
// Bench for param_seq_shifter: an 8-bit single-step instance and a 16-bit 4-step instance.
module tb_param_seq_shifter;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_seq_shifter_if #(.WIDTH(8))  bus_a ();
    param_seq_shifter_if #(.WIDTH(16)) bus_b ();

    param_seq_shifter #(.WIDTH(8),  .STEP(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    param_seq_shifter #(.WIDTH(16), .STEP(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic        sel;
    logic        drv_valid;
    logic [15:0] drv_data;
    logic [3:0]  drv_amt;
    logic        drv_dir;
    logic [1:0]  drv_mode;
    logic        drv_fill;
    logic        drv_out_ready;

    assign bus_a.in_valid  = drv_valid & ~sel;
    assign bus_a.data_in   = drv_data[7:0];
    assign bus_a.amt_in    = drv_amt[2:0];
    assign bus_a.dir_in    = drv_dir;
    assign bus_a.mode_in   = drv_mode;
    assign bus_a.fill_in   = drv_fill;
    assign bus_a.out_ready = drv_out_ready;
    assign bus_b.in_valid  = drv_valid & sel;
    assign bus_b.data_in   = drv_data;
    assign bus_b.amt_in    = drv_amt;
    assign bus_b.dir_in    = drv_dir;
    assign bus_b.mode_in   = drv_mode;
    assign bus_b.fill_in   = drv_fill;
    assign bus_b.out_ready = drv_out_ready;

    logic        obs_in_ready, obs_out_valid, obs_busy, obs_carry;
    logic [15:0] obs_data;
    assign obs_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign obs_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign obs_busy      = sel ? bus_b.busy      : bus_a.busy;
    assign obs_carry     = sel ? bus_b.carry_out : bus_a.carry_out;
    assign obs_data      = sel ? bus_b.data_out  : {8'h00, bus_a.data_out};

    int total = 0;
    int bad   = 0;
    int cur_lat;
    logic [16:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: apply amt single-bit steps on a w-bit word; returns {carry, word}.
    function automatic logic [16:0] model(input logic [15:0] d, input int w, input int amt,
                                          input logic dir, input logic [1:0] mode, input logic fill);
        logic [15:0] v;
        logic [16:0] m;
        logic        c;
        logic        fb;
        m = (17'd1 << w) - 17'd1;
        v = d & m[15:0];
        c = 1'b0;
        for (int i = 0; i < amt; i++) begin
            if (dir) begin
                c  = v[w-1];
                fb = (mode == 2'b00) ? 1'b0 : (mode == 2'b01) ? v[0] : (mode == 2'b10) ? fill : v[w-1];
                v  = ((v << 1) | {15'b0, fb}) & m[15:0];
            end else begin
                c  = v[0];
                fb = (mode == 2'b00) ? 1'b0 : (mode == 2'b01) ? v[w-1] : (mode == 2'b10) ? fill : v[0];
                v  = v >> 1;
                v[w-1] = fb;
            end
        end
        return {c, v};
    endfunction

    task automatic send(input logic s, input logic [15:0] d, input int amt, input logic dir,
                        input logic [1:0] mode, input logic fill, input logic use_exp,
                        input logic [16:0] expv);
        int n;
        int w;
        int step;
        sel  = s;
        w    = s ? 16 : 8;
        step = s ? 4 : 1;
        n = 0;
        #1;
        while (!obs_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(obs_in_ready), 32'd1);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_amt   = 4'(amt);
        drv_dir   = dir;
        drv_mode  = mode;
        drv_fill  = fill;
        if (use_exp) exp_q.push_back(expv);
        else         exp_q.push_back(model(d, w, amt, dir, mode, fill));
        cur_lat = (amt == 0) ? 0 : (amt + step - 1) / step;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_data  = 16'($urandom);
        drv_amt   = 4'($urandom_range(0, 15));
        drv_dir   = 1'($urandom_range(0, 1));
        drv_mode  = 2'($urandom_range(0, 3));
        drv_fill  = 1'($urandom_range(0, 1));
    endtask

    // Expects out_ready high: compares while DONE, then checks the return to IDLE.
    task automatic collect(input string tag);
        int n;
        logic [16:0] e;
        n = 0;
        while (!obs_out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(cur_lat));
        chk({tag, "_valid"}, 32'(obs_out_valid), 32'd1);
        chk({tag, "_busy"}, 32'(obs_busy), 32'd1);
        chk({tag, "_inrdy_busy"}, 32'(obs_in_ready), 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(obs_data), 32'(e[15:0]));
            chk({tag, "_carry"}, 32'(obs_carry), 32'(e[16]));
        end else begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 32'(obs_out_valid), 32'd0);
        chk({tag, "_inrdy_back"}, 32'(obs_in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] e;
        int n;
        sel = 1'b0; drv_valid = 1'b0; drv_data = '0; drv_amt = '0;
        drv_dir = 1'b0; drv_mode = 2'b00; drv_fill = 1'b0; drv_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_inrdy", 32'(bus_a.in_ready), 32'd1);
        chk("rst_a_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_a_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_a_data", 32'(bus_a.data_out), 32'd0);
        chk("rst_a_carry", 32'(bus_a.carry_out), 32'd0);
        chk("rst_b_inrdy", 32'(bus_b.in_ready), 32'd1);
        chk("rst_b_valid", 32'(bus_b.out_valid), 32'd0);
        chk("rst_b_data", 32'(bus_b.data_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        send(0, 16'h00B4, 3, 1'b0, 2'b00, 1'b0, 1, {1'b1, 16'h0016}); collect("lsr");
        send(0, 16'h0081, 2, 1'b1, 2'b01, 1'b0, 1, {1'b0, 16'h0007}); collect("edge_l");
        send(0, 16'h0090, 4, 1'b0, 2'b01, 1'b0, 1, {1'b0, 16'h00F9}); collect("edge_r");
        send(0, 16'h00A5, 4, 1'b1, 2'b11, 1'b0, 1, {1'b0, 16'h005A}); collect("rot_l");
        send(0, 16'h000F, 2, 1'b0, 2'b10, 1'b1, 1, {1'b1, 16'h00C3}); collect("fill_r");
        send(0, 16'h005C, 0, 1'b1, 2'b11, 1'b1, 1, {1'b0, 16'h005C}); collect("amt0_a");
        send(1, 16'h8001, 9, 1'b1, 2'b00, 1'b0, 1, {1'b0, 16'h0200}); collect("multi_b");
        send(1, 16'hBEEF, 0, 1'b0, 2'b01, 1'b0, 1, {1'b0, 16'hBEEF}); collect("amt0_b");

        // Backpressure: result held while a second request waits.
        drv_out_ready = 1'b0;
        send(0, 16'h0033, 5, 1'b1, 2'b11, 1'b0, 0, '0);
        n = 0;
        while (!obs_out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_lat", 32'(n), 32'(cur_lat));
        e = exp_q.pop_front();
        drv_valid = 1'b1; drv_data = 16'h00C7; drv_amt = 4'd1;
        drv_dir = 1'b0; drv_mode = 2'b00; drv_fill = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(obs_out_valid), 32'd1);
            chk("bp_data", 32'(obs_data), 32'(e[15:0]));
            chk("bp_carry", 32'(obs_carry), 32'(e[16]));
            chk("bp_inrdy", 32'(obs_in_ready), 32'd0);
        end
        drv_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(obs_out_valid), 32'd0);
        chk("bp_hs_busy", 32'(obs_busy), 32'd0);
        chk("bp_hs_inrdy", 32'(obs_in_ready), 32'd1);
        exp_q.push_back(model(16'h00C7, 8, 1, 1'b0, 2'b00, 1'b0));
        cur_lat = 1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        chk("bp_acc_busy", 32'(obs_busy), 32'd1);
        collect("bp_second");

        // Asynchronous reset in the middle of a shift.
        send(0, 16'h00B4, 7, 1'b0, 2'b00, 1'b0, 0, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
        chk("mid_rst_data", 32'(bus_a.data_out), 32'd0);
        chk("mid_rst_inrdy", 32'(bus_a.in_ready), 32'd1);
        void'(exp_q.pop_back());
        @(negedge clk) rst_n = 1'b1;
        send(0, 16'h00E1, 5, 1'b0, 2'b01, 1'b0, 0, '0); collect("post_rst");

        for (int i = 0; i < 20; i++) begin
            send(0, 16'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, '0);
            collect("rnd_a");
        end
        for (int i = 0; i < 12; i++) begin
            send(1, 16'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, '0);
            collect("rnd_b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_seq_shifter.md
Name: param_seq_shifter

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational shifter.
- Shifts a WIDTH-bit word left or right by a runtime amount, at up to STEP bit positions per clock.
- Four fill modes: zero, edge-replicate, external fill bit, rotate.
- Sits behind a valid/ready request port and a valid/ready result port in the ALU datapath; also reports the last bit shifted out.

Parameters:
- WIDTH, 8, data word width in bits, >=2.
- STEP, 1, maximum bit positions shifted per clock, 1..WIDTH.
- AW, $clog2(WIDTH), width of the shift amount field (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- data_in  in  WIDTH  operand.
- amt_in  in  AW  shift amount, 0..WIDTH-1.
- dir_in  in  1  1 = left, 0 = right.
- mode_in  in  2  00 zero fill; 01 edge replicate; 10 fill_in; 11 rotate.
- fill_in  in  1  fill bit for mode 10.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- data_out  out  WIDTH  shifted result.
- carry_out  out  1  last bit that left the word.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset is asynchronous and active-low:
  - state goes to IDLE;
  - data_out, carry_out, out_valid and busy go to 0;
  - in_ready goes to 1;
  - the remaining-amount counter goes to 0.
  - Reset asserted mid-operation discards the operation; no partial result is presented.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, all request fields are latched into the working register.
  - carry is cleared and remaining is set to amt_in.
  - If amt_in==0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each clock shifts by s = min(remaining, STEP), then remaining -= s.
  - Go to DONE on the edge where remaining reaches 0.
  - in_ready=0.
- DONE:
  - out_valid=1. data_out and carry_out are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency, counted from the accepting edge:
  - amt 0: out_valid is high from the next cycle.
  - amt>0: DONE is entered ceil(amt/STEP) edges after the accept edge.
- Fill rules for vacated positions:
  - Mode 00: fill with 0.
  - Mode 01, left shift: replicate bit 0.
  - Mode 01, right shift: replicate the MSB (arithmetic shift).
  - Mode 10: fill with the latched fill_in.
  - Mode 11: bits leaving one end re-enter at the other.
- carry_out:
  - Holds the final bit to exit the MSB (left shift) or the LSB (right shift).
  - For rotate, it is the last bit that wrapped.
  - It is 0 when amt==0.
- in_valid is ignored while busy. Inputs may change freely once accepted.
- A multi-bit step must give the same result as s single-bit steps.

Decomposition:
- shifter_pkg contains:
  - the mode encoding (MODE_ZERO, MODE_EDGE, MODE_FILL, MODE_ROT);
  - the DIR_LEFT and DIR_RIGHT constants;
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step is a combinational one-step shifter.
  - Inputs: word, s (0..STEP), dir, mode and fill.
  - Outputs: the new word and the carry.
  - Instantiated once inside param_seq_shifter.

Test Plan:
1. Logical right shift, WIDTH=8, STEP=1. Stimulus: data_in=0xB4, amt=3, dir=0, mode=00. Required: data_out=0x16, carry_out=1, out_valid 3 edges after accept.
2. Edge-replicate shifts, WIDTH=8, STEP=1:
   - Left: 0x81, amt=2, dir=1, mode=01 -> data_out=0x07, carry_out=0.
   - Right: 0x90, amt=4, dir=0, mode=01 -> data_out=0xF9, carry_out=0.
3. Rotate and fill, WIDTH=8, STEP=1:
   - Rotate: 0xA5, amt=4, dir=1, mode=11 -> data_out=0x5A, carry_out=0, latency 4.
   - External fill: 0x0F, amt=2, dir=0, mode=10, fill_in=1 -> data_out=0xC3, carry_out=1.
4. Zero amount and multi-step:
   - amt=0, any data: data_out=data_in, carry_out=0, out_valid the cycle after accept.
   - WIDTH=16, STEP=4: 0x8001, amt=9, dir=1, mode=00 -> data_out=0x0200, carry_out=0, latency 3 (steps of 4, 4, 1).
5. Backpressure. Stimulus: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and different data offered. Required: data_out, carry_out and out_valid stay stable; in_ready=0; the second request is not accepted until the cycle after the out handshake.
6. Reset mid-SHIFT. Stimulus: assert rst_n=0 asynchronously during an amt=7 shift. Required: immediately out_valid=0, busy=0, data_out=0, in_ready=1; after release, a new request completes normally.
